// File: rtl/router_rx_deserializer.sv
// router_rx_deserializer: N independent bit-serial ingress ports, each decoding a
// destination header and DATA_W-bit words. Define ROUTER_RX_STATS_EN for per-port packet/error counters.
module router_rx_deserializer #(
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned PAD_CYCLES = 5,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_PORTS-1:0]           din,
  input  logic [NUM_PORTS-1:0]           valid_n,
  input  logic [NUM_PORTS-1:0]           frame_n,
  output logic [NUM_PORTS-1:0]           hdr_valid,
  output logic [NUM_PORTS*ADDR_BITS-1:0] hdr_addr,
  output logic [NUM_PORTS-1:0]           rx_valid,
  output logic [NUM_PORTS*DATA_W-1:0]    rx_data,
  output logic [NUM_PORTS-1:0]           rx_last,
  output logic [NUM_PORTS-1:0]           rx_err,
  output logic [NUM_PORTS-1:0]           busy_o
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]        pkt_cnt,
  output logic [NUM_PORTS*16-1:0]        err_cnt
`endif
);

  // One shared counter per port serves address index, pad count and bit index.
  localparam int unsigned CNT_MAX0 = (ADDR_BITS > DATA_W) ? ADDR_BITS : DATA_W;
  localparam int unsigned CNT_MAX  = (PAD_CYCLES > CNT_MAX0) ? PAD_CYCLES : CNT_MAX0;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PAD, S_DATA} state_t;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   hdr_set, word_set, last_set, err_set;

    logic                   hdr_v_q, rx_v_q, rx_l_q, err_q, busy_q;
    logic [ADDR_BITS-1:0]   hdr_a_q;
    logic [DATA_W-1:0]      rx_d_q;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      hdr_set  = 1'b0;
      word_set = 1'b0;
      last_set = 1'b0;
      err_set  = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!frame_n[p]) begin
            addr_d    = '0;
            addr_d[0] = din[p];
            data_d    = '0;
            if (ADDR_BITS == 1) begin
              hdr_set = 1'b1;
              cnt_d   = '0;
              state_d = (PAD_CYCLES == 0) ? S_DATA : S_PAD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (frame_n[p]) begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            for (int unsigned b = 0; b < ADDR_BITS; b++) begin
              if (cnt_q == CNT_W'(b)) addr_d[b] = din[p];
            end
            if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
              hdr_set = 1'b1;
              cnt_d   = '0;
              state_d = (PAD_CYCLES == 0) ? S_DATA : S_PAD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAD: begin
          if (frame_n[p]) begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (!valid_n[p]) begin
            for (int unsigned b = 0; b < DATA_W; b++) begin
              if (cnt_q == CNT_W'(b)) data_d[b] = din[p];
            end
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              word_set = 1'b1;
              last_set = frame_n[p];
              cnt_d    = '0;
              if (frame_n[p]) state_d = S_IDLE;
            end else if (frame_n[p]) begin
              err_set = 1'b1;
              cnt_d   = '0;
              data_d  = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (frame_n[p]) begin
            err_set = 1'b1;
            cnt_d   = '0;
            data_d  = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        addr_q  <= '0;
        data_q  <= '0;
        hdr_v_q <= 1'b0;
        hdr_a_q <= '0;
        rx_v_q  <= 1'b0;
        rx_d_q  <= '0;
        rx_l_q  <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        data_q  <= data_d;
        hdr_v_q <= hdr_set;
        if (hdr_set) hdr_a_q <= addr_d;
        rx_v_q  <= word_set;
        if (word_set) rx_d_q <= data_d;
        rx_l_q  <= last_set;
        err_q   <= err_set;
        busy_q  <= (state_d != S_IDLE);
      end
    end

    assign hdr_valid[p]                         = hdr_v_q;
    assign hdr_addr[p*ADDR_BITS +: ADDR_BITS]   = hdr_a_q;
    assign rx_valid[p]                          = rx_v_q;
    assign rx_data[p*DATA_W +: DATA_W]          = rx_d_q;
    assign rx_last[p]                           = rx_l_q;
    assign rx_err[p]                            = err_q;
    assign busy_o[p]                            = busy_q;

`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_q, errc_q;

    // Counters step on the same edge that raises their pulse, so they read updated alongside it.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pkt_q  <= '0;
        errc_q <= '0;
      end else begin
        if (last_set && (pkt_q != '1)) pkt_q <= pkt_q + 16'd1;
        if (err_set && (errc_q != '1)) errc_q <= errc_q + 16'd1;
      end
    end

    assign pkt_cnt[p*16 +: 16] = pkt_q;
    assign err_cnt[p*16 +: 16] = errc_q;
`endif
  end

endmodule

// File: tb/tb_router_rx_deserializer.sv
// Scoreboard bench for router_rx_deserializer: expectations are queued per port as
// packets are driven and popped by a negedge monitor when the DUT pulses.
module tb_router_rx_deserializer;
  localparam int unsigned NP = 16;
  localparam int unsigned AB = 4;
  localparam int unsigned PC = 5;
  localparam int unsigned DW = 8;

  logic                clock = 1'b0;
  logic                reset_n = 1'b1;
  logic [NP-1:0]       din = '0;
  logic [NP-1:0]       valid_n = '1;
  logic [NP-1:0]       frame_n = '1;
  logic [NP-1:0]       hdr_valid;
  logic [NP*AB-1:0]    hdr_addr;
  logic [NP-1:0]       rx_valid;
  logic [NP*DW-1:0]    rx_data;
  logic [NP-1:0]       rx_last;
  logic [NP-1:0]       rx_err;
  logic [NP-1:0]       busy_o;
`ifdef ROUTER_RX_STATS_EN
  logic [NP*16-1:0]    pkt_cnt;
  logic [NP*16-1:0]    err_cnt;
`endif

  router_rx_deserializer #(
    .NUM_PORTS (NP),
    .ADDR_BITS (AB),
    .PAD_CYCLES(PC),
    .DATA_W    (DW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .din      (din),
    .valid_n  (valid_n),
    .frame_n  (frame_n),
    .hdr_valid(hdr_valid),
    .hdr_addr (hdr_addr),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_last  (rx_last),
    .rx_err   (rx_err),
    .busy_o   (busy_o)
`ifdef ROUTER_RX_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  initial forever #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [AB-1:0] exp_hdr  [NP][$];
  logic [DW:0]   exp_word [NP][$];
  int            exp_err  [NP];
  int            exp_pkt  [NP];
  int            exp_errn [NP];

  logic [AB-1:0] m_a;
  logic [DW:0]   m_w;

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += exp_hdr[p].size() + exp_word[p].size() + exp_err[p];
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard comparator: every output pulse must match the oldest expectation for its port.
  always @(negedge clock) begin
    for (int p = 0; p < NP; p++) begin
      if (hdr_valid[p] === 1'b1) begin
        tests++;
        if (exp_hdr[p].size() == 0) begin
          fails++;
          $display("FAIL hdr_unexpected port %0d: got addr %h, required no pulse", p, hdr_addr[p*AB +: AB]);
        end else begin
          m_a = exp_hdr[p].pop_front();
          if (hdr_addr[p*AB +: AB] !== m_a) begin
            fails++;
            $display("FAIL hdr_addr port %0d: got %h required %h", p, hdr_addr[p*AB +: AB], m_a);
          end
        end
      end
      if (rx_valid[p] === 1'b1) begin
        tests++;
        if (exp_word[p].size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected port %0d: got data %h last %b, required no pulse", p, rx_data[p*DW +: DW], rx_last[p]);
        end else begin
          m_w = exp_word[p].pop_front();
          if ({rx_last[p], rx_data[p*DW +: DW]} !== m_w) begin
            fails++;
            $display("FAIL rx_word port %0d: got last %b data %h required last %b data %h",
                     p, rx_last[p], rx_data[p*DW +: DW], m_w[DW], m_w[DW-1:0]);
          end
        end
      end
      if (rx_err[p] === 1'b1) begin
        tests++;
        if (exp_err[p] == 0 || rx_valid[p] !== 1'b0) begin
          fails++;
          $display("FAIL rx_err port %0d: got err with rx_valid %b, pending errs %0d", p, rx_valid[p], exp_err[p]);
        end else begin
          exp_err[p]--;
        end
      end
    end
  end

  task automatic send_pkt(input int p, input logic [AB-1:0] addr, input logic [23:0] bytes,
                          input int nbytes, input int stall_at, input int stall_n);
    logic [7:0] b;
    exp_hdr[p].push_back(addr);
    for (int k = 0; k < nbytes; k++) begin
      b = bytes[k*8 +: 8];
      exp_word[p].push_back({(k == nbytes - 1), b});
    end
    exp_pkt[p]++;
    for (int i = 0; i < AB; i++) begin
      frame_n[p] = 1'b0; valid_n[p] = 1'b1; din[p] = addr[i];
      tick();
    end
    tests++;
    if (busy_o[p] !== 1'b1) begin
      fails++;
      $display("FAIL busy_mid port %0d: got %b required 1", p, busy_o[p]);
    end
    for (int i = 0; i < PC; i++) begin
      din[p] = 1'($urandom); valid_n[p] = 1'($urandom);
      tick();
    end
    for (int k = 0; k < nbytes; k++) begin
      b = bytes[k*8 +: 8];
      for (int j = 0; j < DW; j++) begin
        if (k*8 + j == stall_at) begin
          for (int s = 0; s < stall_n; s++) begin
            valid_n[p] = 1'b1; din[p] = 1'($urandom);
            tick();
          end
        end
        valid_n[p] = 1'b0; din[p] = b[j];
        frame_n[p] = (k == nbytes - 1) && (j == DW - 1);
        tick();
      end
    end
    frame_n[p] = 1'b1; valid_n[p] = 1'b1; din[p] = 1'b0;
  endtask

  // pad_abort >= 0 raises frame_n on that pad cycle; otherwise abort after data_bits
  // payload bits, on a valid bit (with_valid=1) or an idle bit (with_valid=0).
  task automatic send_abort(input int p, input logic [AB-1:0] addr, input int pad_abort,
                            input int data_bits, input bit with_valid);
    exp_hdr[p].push_back(addr);
    exp_err[p]++;
    exp_errn[p]++;
    for (int i = 0; i < AB; i++) begin
      frame_n[p] = 1'b0; valid_n[p] = 1'b1; din[p] = addr[i];
      tick();
    end
    for (int i = 0; i < PC; i++) begin
      if (i == pad_abort) begin
        frame_n[p] = 1'b1;
        tick();
        frame_n[p] = 1'b1; valid_n[p] = 1'b1; din[p] = 1'b0;
        return;
      end
      din[p] = 1'($urandom); valid_n[p] = 1'($urandom);
      tick();
    end
    for (int j = 0; j < data_bits; j++) begin
      valid_n[p] = 1'b0; din[p] = 1'($urandom);
      tick();
    end
    frame_n[p] = 1'b1; valid_n[p] = !with_valid; din[p] = 1'b1;
    tick();
    frame_n[p] = 1'b1; valid_n[p] = 1'b1; din[p] = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    tests++;
    if ({hdr_valid, rx_valid, rx_last, rx_err, busy_o} !== '0) begin
      fails++;
      $display("FAIL reset_pulses: got %h required 0", {hdr_valid, rx_valid, rx_last, rx_err, busy_o});
    end
    tests++;
    if ({hdr_addr, rx_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0", {hdr_addr, rx_data});
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_port3();
    send_pkt(3, 4'hA, 24'h0000C5, 1, -1, 0);
    tests++;
    if (busy_o[3] !== 1'b0) begin
      fails++;
      $display("FAIL busy_end port 3: got %b required 0", busy_o[3]);
    end
    repeat (2) tick();
    tests++;
    if (rx_data[31:24] !== 8'hC5 || hdr_addr[15:12] !== 4'hA) begin
      fails++;
      $display("FAIL held_p3: got data %h addr %h required c5 a", rx_data[31:24], hdr_addr[15:12]);
    end
    tests++;
    if (pending() !== 0) begin
      fails++;
      $display("FAIL drain_p3: got %0d pending required 0", pending());
    end
  endtask

  task automatic test_multi_byte_stall();
    send_pkt(0, 4'h1, {8'hFF, 8'h80, 8'h01}, 3, 11, 2);
    repeat (2) tick();
    tests++;
    if (rx_data[7:0] !== 8'hFF || busy_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL held_p0: got data %h busy %b required ff 0", rx_data[7:0], busy_o[0]);
    end
    tests++;
    if (pending() !== 0) begin
      fails++;
      $display("FAIL drain_p0: got %0d pending required 0", pending());
    end
  endtask

  task automatic test_pad_abort();
    send_abort(5, 4'h3, 1, 0, 1'b0);
    tests++;
    if (busy_o[5] !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_err port 5: got %b required 0", busy_o[5]);
    end
    repeat (2) tick();
    tests++;
    if (pending() !== 0 || busy_o[5] !== 1'b0) begin
      fails++;
      $display("FAIL drain_p5: got %0d pending busy %b required 0 0", pending(), busy_o[5]);
    end
  endtask

  task automatic test_data_abort_back_to_back();
    send_abort(7, 4'hE, -1, 5, 1'b0);
    send_pkt(7, 4'h2, 24'h00003C, 1, -1, 0);
    repeat (2) tick();
    tests++;
    if (hdr_addr[31:28] !== 4'h2 || rx_data[63:56] !== 8'h3C) begin
      fails++;
      $display("FAIL held_p7: got addr %h data %h required 2 3c", hdr_addr[31:28], rx_data[63:56]);
    end
    tests++;
    if (pending() !== 0) begin
      fails++;
      $display("FAIL drain_p7: got %0d pending required 0", pending());
    end
  endtask

  task automatic test_other_errors();
    send_abort(4, 4'h7, -1, 3, 1'b1);
    send_abort(6, 4'h1, -1, 0, 1'b0);
    repeat (2) tick();
    tests++;
    if (pending() !== 0) begin
      fails++;
      $display("FAIL drain_errs: got %0d pending required 0", pending());
    end
  endtask

  task automatic test_back_to_back();
    send_pkt(2, 4'hB, 24'h00005A, 1, -1, 0);
    send_pkt(2, 4'h4, {8'h00, 8'hA5, 8'h0F}, 2, -1, 0);
    repeat (2) tick();
    tests++;
    if (pending() !== 0 || rx_data[23:16] !== 8'hA5) begin
      fails++;
      $display("FAIL drain_b2b: got %0d pending data %h required 0 a5", pending(), rx_data[23:16]);
    end
  endtask

  task automatic test_all_ports();
    logic [NP*AB-1:0] ea;
    logic [NP*DW-1:0] ed;
    for (int p = 0; p < NP; p++) begin
      ea[p*AB +: AB] = AB'(p);
      ed[p*DW +: DW] = ~8'(p);
    end
    done_cnt = 0;
    for (int p = 0; p < NP; p++) begin
      fork
        automatic int pp = p;
        begin
          send_pkt(pp, AB'(pp), {16'h0000, ~8'(pp)}, 1, -1, 0);
          done_cnt++;
        end
      join_none
    end
    repeat (AB) tick();
    tests++;
    if (hdr_valid !== '1 || hdr_addr !== ea) begin
      fails++;
      $display("FAIL all_hdr: got valid %h addr %h required ffff %h", hdr_valid, hdr_addr, ea);
    end
    repeat (PC + DW) tick();
    tests++;
    if (rx_valid !== '1 || rx_last !== '1 || rx_data !== ed) begin
      fails++;
      $display("FAIL all_rx: got valid %h last %h data %h required ffff ffff %h", rx_valid, rx_last, rx_data, ed);
    end
    for (int i = 0; i < 50 && done_cnt < NP; i++) tick();
    tests++;
    if (done_cnt !== NP) begin
      fails++;
      $display("FAIL all_done: got %0d senders finished required %0d", done_cnt, NP);
    end
    repeat (2) tick();
    tests++;
    if (pending() !== 0) begin
      fails++;
      $display("FAIL drain_all: got %0d pending required 0", pending());
    end
  endtask

  task automatic test_reset_mid_data();
    exp_hdr[9].push_back(4'hD);
    for (int i = 0; i < AB; i++) begin
      frame_n[9] = 1'b0; valid_n[9] = 1'b1; din[9] = (i != 1);
      tick();
    end
    for (int i = 0; i < PC; i++) tick();
    for (int j = 0; j < 3; j++) begin
      valid_n[9] = 1'b0; din[9] = 1'b1;
      tick();
    end
    tests++;
    if (busy_o[9] !== 1'b1) begin
      fails++;
      $display("FAIL busy_pre_reset port 9: got %b required 1", busy_o[9]);
    end
`ifdef ROUTER_RX_STATS_EN
    for (int p = 0; p < NP; p++) begin
      tests++;
      if (pkt_cnt[p*16 +: 16] !== 16'(exp_pkt[p]) || err_cnt[p*16 +: 16] !== 16'(exp_errn[p])) begin
        fails++;
        $display("FAIL stats port %0d: got pkt %0d err %0d required %0d %0d",
                 p, pkt_cnt[p*16 +: 16], err_cnt[p*16 +: 16], exp_pkt[p], exp_errn[p]);
      end
    end
`endif
    reset_n = 1'b0;
    frame_n[9] = 1'b1; valid_n[9] = 1'b1; din[9] = 1'b0;
    #1;
    tests++;
    if ({hdr_valid, rx_valid, rx_last, rx_err, busy_o} !== '0 || {hdr_addr, rx_data} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got pulses %h addr %h data %h required 0",
               {hdr_valid, rx_valid, rx_last, rx_err, busy_o}, hdr_addr, rx_data);
    end
`ifdef ROUTER_RX_STATS_EN
    tests++;
    if ({pkt_cnt, err_cnt} !== '0) begin
      fails++;
      $display("FAIL midreset_stats: got pkt %h err %h required 0", pkt_cnt, err_cnt);
    end
`endif
    for (int p = 0; p < NP; p++) begin
      exp_pkt[p] = 0;
      exp_errn[p] = 0;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    tests++;
    if (rx_err !== '0 || busy_o !== '0) begin
      fails++;
      $display("FAIL post_release: got err %h busy %h required 0 0", rx_err, busy_o);
    end
    send_pkt(9, 4'h6, 24'h0000A7, 1, -1, 0);
    repeat (2) tick();
    tests++;
    if (pending() !== 0 || rx_data[79:72] !== 8'hA7 || hdr_addr[39:36] !== 4'h6) begin
      fails++;
      $display("FAIL after_reset_p9: got %0d pending data %h addr %h required 0 a7 6",
               pending(), rx_data[79:72], hdr_addr[39:36]);
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      exp_err[p]  = 0;
      exp_pkt[p]  = 0;
      exp_errn[p] = 0;
    end
    test_reset();
    test_single_port3();
    test_multi_byte_stall();
    test_pad_abort();
    test_data_abort_back_to_back();
    test_other_errors();
    test_back_to_back();
    test_all_ports();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
